ram4k_arbiter: RTL and testbench
================================

RAM4K_ARBITER -- requirements
Module: ram4k_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 16, word width.
- ADDR_W, default 12, address width; depth is 2**ADDR_W.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  requester A access request, level.
- a_load  in  1  requester A write enable (1 = write, 0 = read).
- a_address  in  ADDR_W  requester A word address.
- a_value  in  DATA_W  requester A write data.
- a_ack  out  1  requester A completion pulse.
- a_out  out  DATA_W  requester A read data.
- b_req, b_load, b_address, b_value, b_ack, b_out  same as A, for requester B.
- ram_value  out  DATA_W  to RAM value input.
- ram_load  out  1  to RAM load input.
- ram_address  out  ADDR_W  to RAM address input.
- ram_out  in  DATA_W  from RAM out; combinational read of ram_address.
- busy  out  1  high while the clear sequence runs.

Function
REQ-003 FSM states SHALL be: IDLE, ACCESS, DONE, plus CLEAR when RAM4K_ARB_CLEAR_EN is defined.

REQ-004 In IDLE with any req high, the block SHALL select a winner, register its load/address/value, and go to ACCESS at the next edge; with no req it stays in IDLE.

REQ-005 Arbitration SHALL be round-robin:
- Single requester: that requester wins.
- Both requesting: the requester pointed to by the priority pointer wins.
- The pointer SHALL move to the non-winner on every grant; after reset it points to A.

REQ-006 In ACCESS, ram_address and ram_value SHALL carry the registered request, and ram_load SHALL equal the registered load (exactly one cycle per write).

REQ-007 At the ACCESS edge, if the access is a read, ram_out SHALL be captured into the winner's *_out; the FSM then goes to DONE.

REQ-008 In DONE, the winner's *_ack SHALL be high for exactly one cycle; the FSM then returns to IDLE.

REQ-009 Latency: req sampled high in IDLE at cycle N -> ACCESS at N+1 -> ack at N+2; maximum throughput is one access per 3 cycles.

REQ-010 Requester handshake rules:
- Hold req, load, address and value stable until ack is sampled high.
- Deassert req at the edge that samples ack, or keep it high to issue a new request.

REQ-011 Req changes outside IDLE SHALL be ignored; the non-winner's request stays pending and is served on the next IDLE.

REQ-012 *_out SHALL update only on that requester's reads and hold its value across writes and the other requester's accesses.

REQ-013 Outside ACCESS and CLEAR, ram_load SHALL be 0; ram_address and ram_value hold their last values.

REQ-014 A write followed by a read to the same address SHALL return the written data.

Reset
REQ-015 Asynchronous reset SHALL immediately force:
- ram_load=0, a_ack=b_ack=0, a_out=b_out=0;
- ram_address=0, ram_value=0;
- priority pointer to A.
The FSM goes to CLEAR if RAM4K_ARB_CLEAR_EN is defined, else to IDLE.

REQ-016 Reset during ACCESS or DONE SHALL abort the access with no ack; a write in progress is not guaranteed to complete.

Configuration
REQ-017 Macro RAM4K_ARB_CLEAR_EN, when defined, SHALL enable the CLEAR sequence:
- After reset release, write 0 to addresses 0 through 2**ADDR_W-1, one per cycle (ram_load=1, ram_value=0, ram_address incrementing).
- busy=1 throughout.
- Requests are held off (no ack) until CLEAR finishes.
- Enter IDLE after the last address; busy goes low in that same cycle.

REQ-018 Without the macro, the CLEAR state and counter SHALL NOT exist, and busy SHALL be tied to 0.

Verification
REQ-019 The bench SHALL cover these scenarios:
- A write 643 <- 0x0003, then A read 643 -> a_ack at N+2 of each request; a_out=0x0003; ram_load high exactly one cycle.
- A and B requesting simultaneously after reset (A write 2669 <- 0x000F, B read 2669) -> A served first, B second; b_out=0x000F.
- Both held high for 4 grants -> grant order A, B, A, B; no ack lost or doubled.
- A read completes (a_out=0x0003), then B writes 643 <- 0x1234 -> a_out still 0x0003.
- Reset asserted during ACCESS of an A write -> ram_load drops immediately; no a_ack; a_out=0; next grant after release goes to A.
- With RAM4K_ARB_CLEAR_EN defined: busy high for 4096 cycles after reset; an A request during CLEAR is acked only after busy falls; a read of 2669 returns 0x0000.

Source files
------------

// File: rtl/ram4k_arbiter.sv
// ---------------------------------------------------------------------------
// ram4k_arbiter
//
// Shares one single-port RAM between two requesters (A and B) using a
// round-robin arbiter and a three-state access sequence:
//   IDLE   -> pick a winner and register its load/address/value
//   ACCESS -> drive the RAM; a read captures ram_out into the winner's *_out
//   DONE   -> one-cycle ack to the winner, then back to IDLE
//
// Optional feature (macro RAM4K_ARB_CLEAR_EN):
//   After reset a CLEAR state writes zero to every RAM word, one per cycle,
//   with busy high. Requests wait until CLEAR has finished. Without the
//   macro there is no CLEAR state and busy is tied low.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   a_req/a_load/a_address/a_value   requester A request (level, held to ack)
//   a_ack, a_out                requester A completion pulse and read data
//   b_*                         same set for requester B
//   ram_value, ram_load, ram_address  drive the RAM
//   ram_out                     combinational RAM read data of ram_address
//   busy                        high while the clear sequence runs
// ---------------------------------------------------------------------------
module ram4k_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_load,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_value,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_out,
  input  logic              b_req,
  input  logic              b_load,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_value,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_out,
  output logic [DATA_W-1:0] ram_value,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy
);

`ifdef RAM4K_ARB_CLEAR_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    CLEAR  = 2'd3
  } state_t;
  localparam state_t RESET_STATE = CLEAR;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t state;
  state_t next_state;

  // ptr_b: 1 when B holds priority on a tie. winner_b: who owns the access.
  logic ptr_b;
  logic winner_b;
  logic reg_load;
  logic any_req;
  logic grant_b;

  // B wins when it is the only requester, or on a tie when it holds priority.
  assign any_req = a_req | b_req;
  assign grant_b = b_req & (~a_req | ptr_b);

  // State register. Reset lands in CLEAR when the clear feature is built in,
  // so the sweep starts on the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-state outputs. Acks and ram_load are decoded from the
  // state so an asynchronous reset drops them immediately.
  always_comb begin
    next_state = state;
    ram_load   = 1'b0;
    a_ack      = 1'b0;
    b_ack      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        ram_load   = reg_load;
        next_state = DONE;
      end
      DONE: begin
        a_ack      = ~winner_b;
        b_ack      = winner_b;
        next_state = IDLE;
      end
`ifdef RAM4K_ARB_CLEAR_EN
      CLEAR: begin
        // The reset state is CLEAR, so gate the write strobe with reset to
        // keep the RAM untouched while reset is still asserted.
        ram_load = ~reset;
        busy     = 1'b1;
        if (ram_address == {ADDR_W{1'b1}}) begin
          next_state = IDLE;
        end
      end
`endif
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: the request is latched at grant time so requesters may change
  // their inputs freely once the access is underway. Read data is captured
  // at the ACCESS edge into the winner's output only. During CLEAR the RAM
  // address register doubles as the sweep counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_b       <= 1'b0;
      winner_b    <= 1'b0;
      reg_load    <= 1'b0;
      ram_address <= '0;
      ram_value   <= '0;
      a_out       <= '0;
      b_out       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            winner_b    <= grant_b;
            ptr_b       <= ~grant_b;
            reg_load    <= grant_b ? b_load    : a_load;
            ram_address <= grant_b ? b_address : a_address;
            ram_value   <= grant_b ? b_value   : a_value;
          end
        end
        ACCESS: begin
          if (!reg_load) begin
            if (winner_b) begin
              b_out <= ram_out;
            end else begin
              a_out <= ram_out;
            end
          end
        end
`ifdef RAM4K_ARB_CLEAR_EN
        CLEAR: begin
          ram_address <= ram_address + ADDR_W'(1);
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram4k_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram4k_arbiter
//
// Bench for ram4k_arbiter. Holds a behavioural RAM attached to the ram_*
// ports and a reference model (shadow memory, expected outputs, round-robin
// priority) that predicts who is granted, when acks arrive and what read
// data each requester sees. Builds with or without RAM4K_ARB_CLEAR_EN.
// ---------------------------------------------------------------------------
module tb_ram4k_arbiter;

  typedef struct {
    bit          load;
    logic [11:0] addr;
    logic [15:0] val;
  } op_t;

`ifdef RAM4K_ARB_CLEAR_EN
  localparam bit EXP_RESET_BUSY = 1'b1;
`else
  localparam bit EXP_RESET_BUSY = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        a_req, a_load, a_ack;
  logic [11:0] a_address;
  logic [15:0] a_value, a_out;
  logic        b_req, b_load, b_ack;
  logic [11:0] b_address;
  logic [15:0] b_value, b_out;
  logic [15:0] ram_value, ram_out;
  logic        ram_load;
  logic [11:0] ram_address;
  logic        busy;

  int checks;
  int errors;

  // Behavioural RAM plus a count of write strobes seen at clock edges.
  logic [15:0] mem [0:4095];
  int          load_cycles;

  // Reference model state.
  logic [15:0] exp_mem [0:4095];
  logic [15:0] exp_a_out;
  logic [15:0] exp_b_out;
  bit          exp_ptr_b;

  op_t qa[$];
  op_t qb[$];
  bit  grant_log[$];

  ram4k_arbiter #(.DATA_W(16), .ADDR_W(12)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_req       (a_req),
    .a_load      (a_load),
    .a_address   (a_address),
    .a_value     (a_value),
    .a_ack       (a_ack),
    .a_out       (a_out),
    .b_req       (b_req),
    .b_load      (b_load),
    .b_address   (b_address),
    .b_value     (b_value),
    .b_ack       (b_ack),
    .b_out       (b_out),
    .ram_value   (ram_value),
    .ram_load    (ram_load),
    .ram_address (ram_address),
    .ram_out     (ram_out),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_out = mem[ram_address];

  always @(posedge clk) begin
    if (ram_load === 1'b1) begin
      mem[ram_address] <= ram_value;
      load_cycles      <= load_cycles + 1;
    end
  end

  task automatic drive_a(input op_t op);
    a_req = 1'b1; a_load = op.load; a_address = op.addr; a_value = op.val;
  endtask

  task automatic drive_b(input op_t op);
    b_req = 1'b1; b_load = op.load; b_address = op.addr; b_value = op.val;
  endtask

  // Round-robin rule: a lone requester wins; on a tie the priority holder wins.
  function automatic bit predict(input bit pa, input bit pb);
    if (pa && pb) return exp_ptr_b;
    return pb;
  endfunction

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 4))
      0: return 12'd643;
      1: return 12'd2669;
      2: return 12'd0;
      3: return 12'd4095;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  // Plays the queued ops of both requesters, holding each request until its
  // ack and checking grant order, latency, write strobes and read data.
  task automatic run_ops(input string name);
    bit   pend_a, pend_b, exp_w, got, first;
    int   cycles, budget, base, exp_lat;
    op_t  op;
    grant_log.delete();
    pend_a = (qa.size() > 0);
    pend_b = (qb.size() > 0);
    if (pend_a) drive_a(qa[0]);
    if (pend_b) drive_b(qb[0]);
    first  = 1'b1;
    cycles = 0;
    base   = load_cycles;
    budget = 10 * (qa.size() + qb.size() + 1);
    exp_w  = predict(pend_a, pend_b);
    while ((pend_a || pend_b) && budget > 0) begin
      @(negedge clk);
      cycles++;
      budget--;
      if (a_ack === 1'b1 || b_ack === 1'b1) begin
        got = (b_ack === 1'b1);
        grant_log.push_back(got);
        checks++;
        if (a_ack === 1'b1 && b_ack === 1'b1) begin
          errors++; $display("[TB] FAIL %s ack_onehot: got a_ack=1 b_ack=1 expected one ack", name);
        end
        checks++;
        if (got !== exp_w) begin
          errors++; $display("[TB] FAIL %s grant_order: got %0d expected %0d (0=A 1=B)", name, got, exp_w);
        end
        exp_lat = first ? 2 : 3;
        checks++;
        if (cycles !== exp_lat) begin
          errors++; $display("[TB] FAIL %s ack_latency: got %0d expected %0d cycles", name, cycles, exp_lat);
        end
        op = exp_w ? qb[0] : qa[0];
        checks++;
        if ((load_cycles - base) !== int'(op.load)) begin
          errors++; $display("[TB] FAIL %s load_pulses: got %0d expected %0d", name, load_cycles - base, op.load);
        end
        if (op.load) exp_mem[op.addr] = op.val;
        else if (exp_w) exp_b_out = exp_mem[op.addr];
        else exp_a_out = exp_mem[op.addr];
        checks++;
        if (a_out !== exp_a_out) begin
          errors++; $display("[TB] FAIL %s a_out: got %h expected %h", name, a_out, exp_a_out);
        end
        checks++;
        if (b_out !== exp_b_out) begin
          errors++; $display("[TB] FAIL %s b_out: got %h expected %h", name, b_out, exp_b_out);
        end
        exp_ptr_b = ~exp_w;
        if (exp_w) begin
          qb.delete(0);
          if (qb.size() > 0) drive_b(qb[0]); else b_req = 1'b0;
        end else begin
          qa.delete(0);
          if (qa.size() > 0) drive_a(qa[0]); else a_req = 1'b0;
        end
        pend_a = (qa.size() > 0);
        pend_b = (qb.size() > 0);
        exp_w  = predict(pend_a, pend_b);
        base   = load_cycles;
        cycles = 0;
        first  = 1'b0;
      end
    end
    checks++;
    if (pend_a || pend_b) begin
      errors++; $display("[TB] FAIL %s timeout: got %0d ops left expected 0", name, qa.size() + qb.size());
      a_req = 1'b0; b_req = 1'b0; qa.delete(); qb.delete();
    end
    @(negedge clk);
    checks++;
    if (a_ack !== 1'b0 || b_ack !== 1'b0) begin
      errors++; $display("[TB] FAIL %s ack_single: got a_ack=%b b_ack=%b expected 0", name, a_ack, b_ack);
    end
  endtask

  // Resets the DUT, checks the reset values, and (when asked) issues an A read
  // of 2669 right at release; that read must wait out any clear sequence.
  task automatic do_reset(input bit clear_req);
    int n;
`ifdef RAM4K_ARB_CLEAR_EN
    int bad, acks_busy;
`endif
    @(negedge clk);
    reset = 1'b1; a_req = 1'b0; b_req = 1'b0;
    #1;
    checks++;
    if (ram_load !== 1'b0) begin errors++; $display("[TB] FAIL rst_ram_load: got %b expected 0", ram_load); end
    checks++;
    if (a_ack !== 1'b0 || b_ack !== 1'b0) begin errors++; $display("[TB] FAIL rst_ack: got %b%b expected 00", a_ack, b_ack); end
    checks++;
    if (a_out !== 16'h0 || b_out !== 16'h0) begin errors++; $display("[TB] FAIL rst_out: got %h/%h expected 0000/0000", a_out, b_out); end
    checks++;
    if (ram_address !== 12'h0 || ram_value !== 16'h0) begin errors++; $display("[TB] FAIL rst_ram_bus: got %h/%h expected 000/0000", ram_address, ram_value); end
    checks++;
    if (busy !== EXP_RESET_BUSY) begin errors++; $display("[TB] FAIL rst_busy: got %b expected %b", busy, EXP_RESET_BUSY); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_ptr_b = 1'b0; exp_a_out = '0; exp_b_out = '0;
    if (clear_req) drive_a('{load: 1'b0, addr: 12'd2669, val: 16'h0});
    #1;
`ifdef RAM4K_ARB_CLEAR_EN
    n = 0; bad = 0; acks_busy = 0;
    while (busy === 1'b1 && n < 5000) begin
      if (ram_load !== 1'b1 || ram_value !== 16'h0 || ram_address !== n[11:0]) bad++;
      if (a_ack === 1'b1 || b_ack === 1'b1) acks_busy++;
      n++;
      @(negedge clk); #1;
    end
    checks++;
    if (n !== 4096) begin errors++; $display("[TB] FAIL clear_busy_len: got %0d expected 4096", n); end
    checks++;
    if (bad !== 0) begin errors++; $display("[TB] FAIL clear_pattern: got %0d bad cycles expected 0", bad); end
    checks++;
    if (acks_busy !== 0) begin errors++; $display("[TB] FAIL clear_ack_held: got %0d acks expected 0", acks_busy); end
    for (int i = 0; i < 4096; i++) exp_mem[i] = 16'h0;
`endif
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy_low: got %b expected 0", busy); end
    if (clear_req) begin
      n = 0;
      while (a_ack !== 1'b1 && n < 10) begin @(negedge clk); #1; n++; end
      checks++;
      if (n !== 2) begin errors++; $display("[TB] FAIL first_req_latency: got %0d expected 2", n); end
      exp_a_out = exp_mem[2669];
      checks++;
      if (a_out !== exp_a_out) begin errors++; $display("[TB] FAIL first_req_data: got %h expected %h", a_out, exp_a_out); end
      exp_ptr_b = 1'b1;
      a_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    do_reset(1'b1);
  endtask

  task automatic test_single_a();
    $display("[TB] test_single_a");
    qa.push_back('{load: 1'b1, addr: 12'd643, val: 16'h0003});
    qa.push_back('{load: 1'b0, addr: 12'd643, val: 16'h0000});
    run_ops("single_a");
    checks++;
    if (a_out !== 16'h0003) begin errors++; $display("[TB] FAIL single_a_data: got %h expected 0003", a_out); end
  endtask

  task automatic test_simultaneous();
    $display("[TB] test_simultaneous");
    do_reset(1'b0);
    qa.push_back('{load: 1'b1, addr: 12'd2669, val: 16'h000F});
    qb.push_back('{load: 1'b0, addr: 12'd2669, val: 16'h0000});
    run_ops("simultaneous");
    checks++;
    if (grant_log.size() !== 2 || grant_log[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL simul_first_a: got %0d grants expected A first", grant_log.size());
    end
    checks++;
    if (b_out !== 16'h000F) begin errors++; $display("[TB] FAIL simul_b_out: got %h expected 000f", b_out); end
  endtask

  task automatic test_round_robin();
    int pattern;
    $display("[TB] test_round_robin");
    for (int i = 0; i < 2; i++) begin
      qa.push_back('{load: 1'($urandom_range(0, 1)), addr: pick_addr(), val: 16'($urandom)});
      qb.push_back('{load: 1'($urandom_range(0, 1)), addr: pick_addr(), val: 16'($urandom)});
    end
    run_ops("round_robin");
    pattern = 0;
    foreach (grant_log[i]) pattern = (pattern << 1) | int'(grant_log[i]);
    checks++;
    if (grant_log.size() !== 4 || pattern !== 4'b0101) begin
      errors++; $display("[TB] FAIL rr_order: got %0d grants pattern %b expected ABAB", grant_log.size(), pattern);
    end
  endtask

  task automatic test_out_hold();
    $display("[TB] test_out_hold");
    qa.push_back('{load: 1'b1, addr: 12'd643, val: 16'h0003});
    qa.push_back('{load: 1'b0, addr: 12'd643, val: 16'h0000});
    run_ops("out_hold_a");
    qb.push_back('{load: 1'b1, addr: 12'd643, val: 16'h1234});
    run_ops("out_hold_b");
    checks++;
    if (a_out !== 16'h0003) begin errors++; $display("[TB] FAIL out_hold: got %h expected 0003", a_out); end
  endtask

  task automatic test_random();
    int na, nb;
    $display("[TB] test_random");
    for (int r = 0; r < 8; r++) begin
      na = $urandom_range(0, 4);
      nb = $urandom_range(0, 4);
      for (int i = 0; i < na; i++)
        qa.push_back('{load: 1'($urandom_range(0, 1)), addr: pick_addr(), val: 16'($urandom)});
      for (int i = 0; i < nb; i++)
        qb.push_back('{load: 1'($urandom_range(0, 1)), addr: pick_addr(), val: 16'($urandom)});
      run_ops("random");
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    logic [15:0] v;
    $display("[TB] test_reset_abort");
    @(negedge clk);
    drive_a('{load: 1'b1, addr: 12'd100, val: 16'hBEEF});
    @(negedge clk);
    checks++;
    if (ram_load !== 1'b1 || ram_address !== 12'd100) begin
      errors++; $display("[TB] FAIL abort_in_access: got load=%b addr=%0d expected 1/100", ram_load, ram_address);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ram_load !== 1'b0) begin errors++; $display("[TB] FAIL abort_load_drop: got %b expected 0", ram_load); end
    checks++;
    if (a_out !== 16'h0) begin errors++; $display("[TB] FAIL abort_a_out: got %h expected 0000", a_out); end
    a_req = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_ack === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("[TB] FAIL abort_no_ack: got %0d acks expected 0", seen); end
    do_reset(1'b0);
    v = 16'($urandom);
    qa.push_back('{load: 1'b1, addr: 12'd100, val: v});
    qb.push_back('{load: 1'b0, addr: 12'd100, val: 16'h0});
    run_ops("after_abort");
    checks++;
    if (grant_log.size() !== 2 || grant_log[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_next_a: got %0d grants expected A first", grant_log.size());
    end
    checks++;
    if (b_out !== v) begin errors++; $display("[TB] FAIL abort_rewrite: got %h expected %h", b_out, v); end
  endtask

  initial begin
    checks = 0; errors = 0; load_cycles = 0;
    reset = 1'b1;
    a_req = 1'b0; a_load = 1'b0; a_address = '0; a_value = '0;
    b_req = 1'b0; b_load = 1'b0; b_address = '0; b_value = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 16'($urandom);
      exp_mem[i] = mem[i];
    end
    exp_ptr_b = 1'b0; exp_a_out = '0; exp_b_out = '0;
    test_reset();
    test_single_a();
    test_simultaneous();
    test_round_robin();
    test_out_hold();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
